// File: rtl/instruc_encoder_pkg.sv
// Shared instruction framing definitions: field widths, header layout and encoder states.
// Header word: bodylen in the low field, opcode above it, all other bits zero.
package Instruc;

    localparam int WORD_WIDTH    = 32;
    localparam int HEADER_WIDTH  = 32;
    localparam int OPCODE_WIDTH  = 8;
    localparam int BODYLEN_WIDTH = 24;

    localparam int HEADER_BODYLEN_OFFSET = 0;
    localparam int HEADER_OPCODE_OFFSET  = BODYLEN_WIDTH;

    typedef logic [OPCODE_WIDTH-1:0]  opcodetype;
    typedef logic [BODYLEN_WIDTH-1:0] bodylentype;
    typedef logic [WORD_WIDTH-1:0]    HostData;

    typedef enum logic [1:0] {
        IDLE,
        SEND_HEADER,
        SEND_BODY
    } encoder_statetype;

    function automatic HostData make_header(input opcodetype opcode, input bodylentype bodylen);
        HostData h;
        h = '0;
        h[HEADER_BODYLEN_OFFSET +: BODYLEN_WIDTH] = bodylen;
        h[HEADER_OPCODE_OFFSET +: OPCODE_WIDTH]   = opcode;
        return h;
    endfunction

endpackage

// File: rtl/instruc_out_reg.sv
// Single-entry valid/ready output register feeding the TX FIFO write port.
// Latency: a loaded word is visible on out_data the cycle after load.
// Backpressure: accepts a new word only when empty or draining this cycle (load_ok).
module instruc_out_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ok,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    assign load_ok = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load_ok) begin
            out_valid <= load;
            if (load) begin
                out_data <= load_data;
            end
        end
    end

endmodule

// File: rtl/instruc_encoder.sv
// Frames host-bound packets: one header word then exactly bodylen body words.
// Latency: header 1 cycle after command accept, each body word 1 cycle after accept.
// Backpressure: out_ready low stalls everything; cmd/body ready follow output register space.
module instruc_encoder #(
    parameter int WORD_WIDTH    = Instruc::WORD_WIDTH,
    parameter int OPCODE_WIDTH  = Instruc::OPCODE_WIDTH,
    parameter int BODYLEN_WIDTH = Instruc::BODYLEN_WIDTH
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [OPCODE_WIDTH-1:0]  cmd_opcode,
    input  logic [BODYLEN_WIDTH-1:0] cmd_bodylen,
    input  logic                     body_valid,
    output logic                     body_ready,
    input  logic [WORD_WIDTH-1:0]    body_data,
    input  logic                     body_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_WIDTH-1:0]    out_data,
    output logic                     busy,
    output logic                     len_err
);

    import Instruc::encoder_statetype;
    import Instruc::IDLE;
    import Instruc::SEND_HEADER;
    import Instruc::SEND_BODY;
    import Instruc::make_header;

    encoder_statetype         state, state_n;
    logic [BODYLEN_WIDTH-1:0] remaining, remaining_n;
    logic                     len_err_n;
    logic                     load, load_ok;
    logic [WORD_WIDTH-1:0]    load_data;
    logic [WORD_WIDTH-1:0]    header;
    logic                     last_due;

    assign header   = WORD_WIDTH'(make_header(cmd_opcode, cmd_bodylen));
    assign last_due = (remaining == BODYLEN_WIDTH'(1));
    assign busy     = (state != IDLE) || out_valid;

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        len_err_n   = len_err;
        cmd_ready   = 1'b0;
        body_ready  = 1'b0;
        load        = 1'b0;
        load_data   = header;
        case (state)
            IDLE: begin
                cmd_ready = resetn && load_ok;
                if (cmd_valid && cmd_ready) begin
                    load        = 1'b1;
                    remaining_n = cmd_bodylen;
                    state_n     = (cmd_bodylen == '0) ? IDLE : SEND_HEADER;
                end
            end
            SEND_HEADER, SEND_BODY: begin
                // Header is always pending in SEND_HEADER, so only a drain frees the register.
                body_ready = (state == SEND_HEADER) ? out_ready : load_ok;
                if (state == SEND_HEADER && out_ready) begin
                    state_n = SEND_BODY;
                end
                if (body_valid && body_ready) begin
                    load        = 1'b1;
                    load_data   = body_data;
                    remaining_n = remaining - BODYLEN_WIDTH'(1);
                    if (body_last != last_due) begin
                        len_err_n = 1'b1;
                    end
                    if (last_due) begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            remaining <= '0;
            len_err   <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            len_err   <= len_err_n;
        end
    end

    instruc_out_reg #(
        .WIDTH (WORD_WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .resetn    (resetn),
        .load      (load),
        .load_data (load_data),
        .load_ok   (load_ok),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

endmodule

// File: doc/instruc_encoder.md
Name: instruc_encoder

Overview:
- Transmit-side counterpart of the instruction decoder: frames outgoing host-bound packets in the same header + body format the decoder consumes.
- A producer (result/readback path) issues a command giving opcode and body length, then streams body words. The block emits one header word followed by exactly bodylen body words into the RxTx TX FIFO.
- Sits between result producers and the RxTx TX FIFO write port.

Parameters:
- WORD_WIDTH, Instruc::WORD_WIDTH, output/body word width; must be >= Instruc::HEADER_WIDTH (32).
- OPCODE_WIDTH, Instruc::OPCODE_WIDTH (8), opcode field width.
- BODYLEN_WIDTH, Instruc::BODYLEN_WIDTH (24), body-length field width.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset; single clock domain.
- cmd_valid  in  1  packet command offered.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_opcode  in  OPCODE_WIDTH  packet opcode.
- cmd_bodylen  in  BODYLEN_WIDTH  number of body words; 0 is legal.
- body_valid  in  1  body word offered.
- body_ready  out  1  body word accepted when body_valid&&body_ready.
- body_data  in  WORD_WIDTH  body word.
- body_last  in  1  producer marks final body word; checked only.
- out_valid  out  1  out_data valid toward TX FIFO.
- out_ready  in  1  TX FIFO not full.
- out_data  out  WORD_WIDTH  header or body word.
- busy  out  1  state != IDLE or out_valid.
- len_err  out  1  sticky framing error flag.

Behaviour:
- Header format: bits [23:0] = bodylen, bits [31:24] = opcode, bits above 31 = 0.
- Output stage is a single register. out_valid/out_data hold stable until out_ready. The register loads when it is empty or draining in the same cycle (load_ok = !out_valid || out_ready).
- States (encoder_statetype):
  - IDLE: cmd_ready = load_ok. On command accept, header loads into the output register; next state is SEND_HEADER, or IDLE if bodylen == 0.
  - SEND_HEADER: header is pending in the output register. body_ready = out_ready. When the header drains, move to SEND_BODY. If a body word is accepted in the same cycle, it loads directly and counts.
  - SEND_BODY: body_ready = load_ok. Each accepted word loads into the output register and decrements remaining. When the word with remaining == 1 is accepted, return to IDLE.
- Latency: header is visible on out_data 1 cycle after command accept. Each body word is visible 1 cycle after acceptance. Back-to-back packets run at full throughput: the next command is accepted in the same cycle the previous final word drains.
- remaining: BODYLEN_WIDTH counter, loaded from cmd_bodylen on accept, never wraps. Maximum 2^24-1 words.
- body_ready = 0 in IDLE. cmd_ready = 0 outside IDLE.
- len_err sets when an accepted body word has body_last=1 with remaining != 1, or body_last=0 with remaining == 1. The word is still forwarded and the count governs framing. len_err clears only on reset.
- Reset values: state IDLE, out_valid 0, out_data 0, remaining 0, len_err 0, cmd_ready 0 during reset and 1 the cycle after.
- Reset mid-packet takes effect on the next edge: the partial packet is dropped and out_valid drops.
- out_ready held low: everything stalls and out_data stays stable, with no loss or duplication.

Decomposition:
- Add to package Instruc:
  - typedef enum logic [1:0] {IDLE, SEND_HEADER, SEND_BODY} encoder_statetype.
  - HEADER_BODYLEN_OFFSET = 0, HEADER_OPCODE_OFFSET = BODYLEN_WIDTH.
  - Function make_header(opcodetype, bodylentype) returning HostData.
- Reuse the existing opcodetype and bodylentype.
- One natural sub-module: instruc_out_reg, the single-entry valid/ready output register.

Test Plan:
- opcode=8'h0C, bodylen=3, words A,B,C, out_ready=1 -> out_data sequence 32'h0C000003, A, B, C on 4 consecutive cycles; len_err=0.
- opcode=1, bodylen=0 followed immediately by opcode=2, bodylen=1, word D -> 32'h01000000, 32'h02000001, D with no bubble; busy drops after D drains.
- bodylen=2, out_ready toggling 1,0,0,1,1 -> out_data is stable while stalled, no duplicates, and body_ready tracks load_ok.
- bodylen=4, body_last on word 2 -> len_err=1 from the cycle after word 2 and stays set. All 4 words are still sent, then IDLE.
- Reset asserted after header + 1 body word of a bodylen=5 packet -> next cycle out_valid=0 and state IDLE. A new bodylen=1 packet then frames correctly.
- bodylen=24'hFFFFFF header check -> out_data[31:0] = {opcode, 24'hFFFFFF}; remaining decrements without wrap over the first 16 words.
